// File: rtl/bram_sched_pkg.sv
// Shared constants and enums for the BRAM port scheduler: default geometry,
// requester indices and clear-engine states.
package bram_sched_pkg;

  localparam int WID_MEM_DEF   = 18;
  localparam int DEPTH_MEM_DEF = 8192;
  localparam int ADDR_W_DEF    = $clog2(DEPTH_MEM_DEF);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_idx_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/bram_rr_arb2.sv
// Two-way round-robin arbiter. A lone requester is granted at once; on
// contention the side that lost the previous contended round wins.
module bram_rr_arb2
  import bram_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  req_idx_e prio;
  logic     contended;

  assign contended = en & req[0] & req[1];

  always_comb begin
    // NOTE: default first so every path assigns grant; otherwise a latch is inferred.
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (prio == REQ_A) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer moves only when both sides competed, so lone traffic never skews fairness.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all sequential state so every flop samples pre-edge values.
    if (reset) begin
      prio <= REQ_A;
    end else if (contended) begin
      prio <= (prio == REQ_A) ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/bram_port_sched.sv
// Schedules two requesters onto a simple dual-port BRAM (one read, one write
// port) and owns a clear engine that sweeps CLR_VAL through every word.
module bram_port_sched
  import bram_sched_pkg::*;
#(
  parameter int                  WID_MEM   = WID_MEM_DEF,
  parameter int                  DEPTH_MEM = DEPTH_MEM_DEF,
  parameter logic [WID_MEM-1:0]  CLR_VAL   = '0,
  localparam int                 ADDR_W    = $clog2(DEPTH_MEM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [1:0]                   rd_valid,
  input  logic [1:0][ADDR_W-1:0]       rd_addr,
  output logic [1:0]                   rd_ready,
  output logic [1:0]                   rd_rvalid,
  output logic [WID_MEM-1:0]           rd_rdata,
  input  logic [1:0]                   wr_valid,
  input  logic [1:0][ADDR_W-1:0]       wr_addr,
  input  logic [1:0][WID_MEM-1:0]      wr_data,
  output logic [1:0]                   wr_ready,
  input  logic                         clear_start,
  output logic                         clear_busy,
  output logic                         clear_done,
  output logic [ADDR_W-1:0]            mem_raddr,
  output logic [ADDR_W-1:0]            mem_waddr,
  output logic [WID_MEM-1:0]           mem_din,
  output logic                         mem_we,
  input  logic [WID_MEM-1:0]           mem_dout
);

  localparam int CNT_W = ADDR_W + 1;

  clr_state_e        state;
  logic [CNT_W-1:0]  clr_cnt;
  logic              last_clr;
  logic [ADDR_W-1:0] raddr_q;
  logic [1:0]        rd_grant;
  logic [1:0]        wr_grant;
  logic              rd_en;
  logic              wr_en;

  assign rd_en    = ~reset;
  assign wr_en    = ~reset & (state == ST_IDLE);
  assign last_clr = (clr_cnt == CNT_W'(DEPTH_MEM - 1));

  bram_rr_arb2 u_rd_arb (
    .clk   (clk),
    .reset (reset),
    .en    (rd_en),
    .req   (rd_valid),
    .grant (rd_grant)
  );

  bram_rr_arb2 u_wr_arb (
    .clk   (clk),
    .reset (reset),
    .en    (wr_en),
    .req   (wr_valid),
    .grant (wr_grant)
  );

  assign rd_ready   = rd_grant;
  assign wr_ready   = wr_grant;
  assign rd_rdata   = mem_dout;
  assign clear_busy = (state == ST_CLEAR);

  // Read address follows the grant in the accept cycle and parks otherwise.
  always_comb begin
    mem_raddr = raddr_q;
    if (reset)            mem_raddr = '0;
    else if (rd_grant[1]) mem_raddr = rd_addr[1];
    else if (rd_grant[0]) mem_raddr = rd_addr[0];
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr[0];
    mem_din   = wr_data[0];
    if (!reset && state == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt[ADDR_W-1:0];
      mem_din   = CLR_VAL;
    end else if (wr_grant[1]) begin
      mem_we    = 1'b1;
      mem_waddr = wr_addr[1];
      mem_din   = wr_data[1];
    end else if (wr_grant[0]) begin
      mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      clr_cnt    <= '0;
      clear_done <= 1'b0;
      rd_rvalid  <= 2'b00;
      raddr_q    <= '0;
    end else begin
      clear_done <= 1'b0;
      rd_rvalid  <= rd_grant;
      if (|rd_grant) raddr_q <= mem_raddr;
      case (state)
        ST_IDLE: begin
          // A write granted alongside clear_start still lands this cycle.
          if (clear_start) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end
        ST_CLEAR: begin
          if (last_clr) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            clear_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_port_sched.sv
// Self-checking bench for bram_port_sched: directed scenarios plus random
// traffic, compared against a word-level memory/arbitration reference model.
module tb_bram_port_sched;
  import bram_sched_pkg::*;

  localparam int AW    = 13;
  localparam int DW    = 18;
  localparam int DEPTH = 8192;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           rd_valid;
  logic [1:0][AW-1:0]   rd_addr;
  logic [1:0]           rd_ready;
  logic [1:0]           rd_rvalid;
  logic [DW-1:0]        rd_rdata;
  logic [1:0]           wr_valid;
  logic [1:0][AW-1:0]   wr_addr;
  logic [1:0][DW-1:0]   wr_data;
  logic [1:0]           wr_ready;
  logic                 clear_start;
  logic                 clear_busy;
  logic                 clear_done;
  logic [AW-1:0]        mem_raddr;
  logic [AW-1:0]        mem_waddr;
  logic [DW-1:0]        mem_din;
  logic                 mem_we;
  logic [DW-1:0]        mem_dout;

  always #5 clk = ~clk;

  bram_port_sched dut (
    .clk         (clk),
    .reset       (reset),
    .rd_valid    (rd_valid),
    .rd_addr     (rd_addr),
    .rd_ready    (rd_ready),
    .rd_rvalid   (rd_rvalid),
    .rd_rdata    (rd_rdata),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .mem_raddr   (mem_raddr),
    .mem_waddr   (mem_waddr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_dout    (mem_dout)
  );

  // Read-first simple dual-port BRAM attached to the scheduler.
  logic [DW-1:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    mem_dout <= mem_arr[mem_raddr];
    if (mem_we) mem_arr[mem_waddr] <= mem_din;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  bit            known   [DEPTH];
  int            rd_fav, wr_fav;
  bit            clr_on;
  int            clr_pos;
  logic [AW-1:0] last_raddr;

  // Requester intent: a request stays pending until the model sees it granted.
  bit            req_rv [2];
  bit            req_wv [2];
  logic [AW-1:0] req_ra [2];
  logic [AW-1:0] req_wa [2];
  logic [DW-1:0] req_wd [2];
  bit            cs;

  logic [1:0]    obs_rd_ready, obs_wr_ready, obs_rvalid;
  logic [DW-1:0] obs_rdata;
  int            n_checks = 0, n_pass = 0, n_fail = 0;
  int            done_count, busy_obs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] pick(input logic [1:0] v, input int fav);
    if (v == 2'b11) return (fav == 0) ? 2'b01 : 2'b10;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int s = $urandom_range(0, 8);
    return (s == 8) ? 13'h1FFF : AW'(s);
  endfunction

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    req_rv[r] = 1'b1;
    req_ra[r] = a;
  endtask

  task automatic set_wr(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_wv[r] = 1'b1;
    req_wa[r] = a;
    req_wd[r] = d;
  endtask

  task automatic model_reset();
    rd_fav = 0; wr_fav = 0; clr_on = 1'b0; clr_pos = 0; last_raddr = '0;
    for (int i = 0; i < 2; i++) begin req_rv[i] = 1'b0; req_wv[i] = 1'b0; end
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    cs = 1'b0;
  endtask

  // Reset for one cycle with a read request pending, which must not produce a response.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rd_valid = 2'b01; rd_addr[0] = '0; wr_valid = 2'b00; clear_start = 1'b0;
    @(posedge clk); #1;
    check("rst_rvalid", 32'(rd_rvalid), 32'(0));
    check("rst_busy", 32'(clear_busy), 32'(0));
    check("rst_done", 32'(clear_done), 32'(0));
    @(negedge clk);
    reset = 1'b0; rd_valid = 2'b00;
    #1;
    check("rst_mem_we", 32'(mem_we), 32'(0));
    check("rst_mem_raddr", 32'(mem_raddr), 32'(0));
    model_reset();
  endtask

  task automatic run_cycle();
    logic [1:0]    erg, ewg, exp_rv;
    logic [DW-1:0] exp_rd;
    bit            exp_known, exp_done, started;
    int            ri, wi;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rd_valid[i] = req_rv[i]; rd_addr[i] = req_ra[i];
      wr_valid[i] = req_wv[i]; wr_addr[i] = req_wa[i]; wr_data[i] = req_wd[i];
    end
    clear_start = cs;
    #1;
    obs_rd_ready = rd_ready;
    obs_wr_ready = wr_ready;
    erg = pick(rd_valid, rd_fav);
    ewg = clr_on ? 2'b00 : pick(wr_valid, wr_fav);
    check("rd_ready", 32'(rd_ready), 32'(erg));
    check("wr_ready", 32'(wr_ready), 32'(ewg));
    ri = erg[1] ? 1 : 0;
    wi = ewg[1] ? 1 : 0;
    exp_rv = erg; exp_known = 1'b0; exp_rd = '0;
    if (erg != 2'b00) begin
      last_raddr = req_ra[ri];
      exp_known  = known[req_ra[ri]];
      exp_rd     = ref_mem[req_ra[ri]];
      req_rv[ri] = 1'b0;
    end
    check("mem_raddr", 32'(mem_raddr), 32'(last_raddr));
    check("mem_we", 32'(mem_we), 32'(clr_on || ewg != 2'b00));
    if (rd_valid == 2'b11) rd_fav = 1 - ri;
    if (ewg != 2'b00 && wr_valid == 2'b11) wr_fav = 1 - wi;
    exp_done = 1'b0;
    started  = !clr_on && cs;
    if (clr_on) begin
      check("clr_waddr", 32'(mem_waddr), 32'(clr_pos));
      check("clr_din", 32'(mem_din), 32'(0));
      ref_mem[clr_pos] = '0;
      known[clr_pos]   = 1'b1;
      clr_pos++;
      if (clr_pos == DEPTH) begin clr_on = 1'b0; exp_done = 1'b1; end
    end else if (ewg != 2'b00) begin
      check("wr_waddr", 32'(mem_waddr), 32'(req_wa[wi]));
      check("wr_din", 32'(mem_din), 32'(req_wd[wi]));
      ref_mem[req_wa[wi]] = req_wd[wi];
      known[req_wa[wi]]   = 1'b1;
      req_wv[wi] = 1'b0;
    end
    if (started) begin clr_on = 1'b1; clr_pos = 0; end
    @(posedge clk); #1;
    obs_rvalid = rd_rvalid;
    obs_rdata  = rd_rdata;
    check("rd_rvalid", 32'(rd_rvalid), 32'(exp_rv));
    if (exp_rv != 2'b00 && exp_known) check("rd_rdata", 32'(rd_rdata), 32'(exp_rd));
    check("clear_busy", 32'(clear_busy), 32'(clr_on));
    check("clear_done", 32'(clear_done), 32'(exp_done));
    if (clear_busy) busy_obs++;
    if (clear_done) done_count++;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int guard;
    reset = 1'b1; rd_valid = '0; rd_addr = '0; wr_valid = '0; wr_addr = '0; wr_data = '0;
    clear_start = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // Seed two words; write contention resolves A first.
    set_wr(0, 13'h0010, 18'h11111);
    set_wr(1, 13'h0020, 18'h22222);
    run_cycle();
    check("seed_wr_a_first", 32'(obs_wr_ready), 32'(2'b01));
    run_cycle();
    check("seed_wr_b_next", 32'(obs_wr_ready), 32'(2'b10));

    // Continuous contention on reads alternates A,B,A,B with one-cycle latency.
    for (int k = 0; k < 6; k++) begin
      set_rd(0, 13'h0010);
      set_rd(1, 13'h0020);
      run_cycle();
      check("alt_grant", 32'(obs_rd_ready), (k % 2 == 0) ? 32'(1) : 32'(2));
      check("alt_rdata", 32'(obs_rdata), (k % 2 == 0) ? 32'h11111 : 32'h22222);
    end
    for (int i = 0; i < 2; i++) req_rv[i] = 1'b0;
    run_cycle();

    // Write then read-back, and same-cycle read/write returns old data.
    set_wr(0, 13'h1FFF, 18'h2ABCD);
    run_cycle();
    set_rd(0, 13'h1FFF);
    run_cycle();
    check("rd_after_wr", 32'(obs_rdata), 32'h2ABCD);
    set_wr(0, 13'h0005, 18'h00AAA);
    run_cycle();
    set_wr(0, 13'h0005, 18'h3FFFF);
    set_rd(1, 13'h0005);
    run_cycle();
    check("rw_same_old", 32'(obs_rdata), 32'h00AAA);
    set_rd(0, 13'h0005);
    run_cycle();
    check("rw_same_new", 32'(obs_rdata), 32'h3FFFF);

    // Only B for 10 cycles, then contention: A must still win first.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      set_rd(1, AW'(k));
      set_wr(1, AW'(100 + k), DW'(k));
      run_cycle();
      check("b_only_rd", 32'(obs_rd_ready), 32'(2'b10));
      check("b_only_wr", 32'(obs_wr_ready), 32'(2'b10));
    end
    set_rd(0, 13'h0001); set_rd(1, 13'h0002);
    set_wr(0, 13'h00C8, 18'h00001); set_wr(1, 13'h00C9, 18'h00002);
    run_cycle();
    check("contend_rd_a_first", 32'(obs_rd_ready), 32'(2'b01));
    check("contend_wr_a_first", 32'(obs_wr_ready), 32'(2'b01));
    run_cycle();

    // Random traffic on a small address pool to force collisions.
    for (int k = 0; k < 400; k++) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_rv[r] && $urandom_range(0, 1) == 1) set_rd(r, rand_addr());
        if (!req_wv[r] && $urandom_range(0, 1) == 1) set_wr(r, rand_addr(), DW'($urandom));
      end
      run_cycle();
    end
    repeat (3) run_cycle();

    // Full clear; a write granted with clear_start completes, B's write waits it out.
    busy_obs = 0; done_count = 0;
    set_wr(0, 13'h0003, 18'h00333);
    cs = 1'b1;
    run_cycle();
    check("wr_with_start", 32'(obs_wr_ready), 32'(2'b01));
    cs = 1'b0;
    set_wr(1, 13'h0007, 18'h00777);
    guard = 0;
    while (clr_on && guard < 9000) begin
      cs = ($urandom_range(0, 63) == 0);
      if (!req_rv[0] && $urandom_range(0, 1) == 1) set_rd(0, AW'($urandom_range(0, DEPTH - 1)));
      run_cycle();
      guard++;
    end
    cs = 1'b0;
    check("busy_cycles", 32'(busy_obs), 32'(8192));
    check("done_once", 32'(done_count), 32'(1));
    req_rv[0] = 1'b0;
    run_cycle();
    check("held_wr_after_clear", 32'(obs_wr_ready), 32'(2'b10));
    set_rd(0, 13'h0000);
    run_cycle();
    check("rd0_cleared", 32'(obs_rdata), 32'(0));
    set_rd(0, 13'h1FFF);
    run_cycle();
    check("rd1fff_cleared", 32'(obs_rdata), 32'(0));
    check("done_still_once", 32'(done_count), 32'(1));

    // Reset at clear cycle 100 aborts the sweep with no done pulse.
    done_count = 0;
    cs = 1'b1;
    run_cycle();
    cs = 1'b0;
    repeat (100) run_cycle();
    do_reset();
    repeat (20) run_cycle();
    check("abort_no_done", 32'(done_count), 32'(0));
    set_wr(1, 13'h00AB, 18'h12345);
    run_cycle();
    check("wr_after_abort", 32'(obs_wr_ready), 32'(2'b10));
    set_rd(0, 13'h00AB);
    run_cycle();
    check("rd_after_abort", 32'(obs_rdata), 32'h12345);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
